// File: rtl/cpu_bus_pkg.sv
// Shared widths, FSM state type and small helpers for the CPU bus decoder.
package cpu_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;
  localparam int UCNT_W = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } bus_state_t;

  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] value);
    return (value == {UCNT_W{1'b1}}) ? value : value + UCNT_W'(1);
  endfunction

endpackage

// File: rtl/clken_div.sv
// Free-running clock divider producing the CPU-cycle tick and a registered phi2.
module clken_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic phi2
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_next;

  assign tick     = (div_cnt == LAST);
  assign div_next = tick ? '0 : div_cnt + CNT_W'(1);

  // phi2 is derived from the next count so it lines up with div_cnt itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phi2    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      phi2    <= (div_next >= HALF);
    end
  end

endmodule

// File: rtl/cpu_bus_decoder.sv
// Address decoder, wait-state sequencer and read mux between a CPU and its memory regions.
module cpu_bus_decoder
  import cpu_bus_pkg::*;
#(
  parameter int                          NUM_REGIONS = 4,
  parameter int                          CLK_DIV     = 4,
  parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE = {16'h8000, 16'h0000, 16'h0000, 16'h0000},
  parameter logic [16*NUM_REGIONS-1:0]   REGION_MASK = {16'h8000, 16'h8000, 16'h0000, 16'h0000},
  parameter logic [4*NUM_REGIONS-1:0]    REGION_WAIT = '0,
  parameter logic [7:0]                  OPEN_BUS    = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_we,
  input  logic [DATA_W-1:0]             cpu_dout,
  output logic [DATA_W-1:0]             cpu_din,
  output logic                          cpu_clken,
  output logic                          phi2,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [NUM_REGIONS-1:0]        we_out,
  output logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W*NUM_REGIONS-1:0] rd_data,
  output logic [UCNT_W-1:0]             unmapped_cnt
);

  logic              tick;
  logic              hit;
  logic [WAIT_W-1:0] sel_wait;
  logic [DATA_W-1:0] sel_data;
  bus_state_t        state;
  logic [WAIT_W-1:0] wcnt;

  clken_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clken_div (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .phi2 (phi2)
  );

  // Scan from the top index down so the lowest matching region overwrites the rest.
  always_comb begin
    cs = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((REGION_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((cpu_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
        cs    = '0;
        cs[i] = 1'b1;
      end
    end
  end

  assign hit = |cs;

  always_comb begin
    sel_wait = '0;
    sel_data = OPEN_BUS;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cs[i]) begin
        sel_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
        sel_data = rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cpu_clken = 1'b0;
    if (rst_n && tick) begin
      case (state)
        ST_RUN:  cpu_clken = (sel_wait == '0);
        ST_WAIT: cpu_clken = (wcnt == '0);
        default: cpu_clken = 1'b0;
      endcase
    end
  end

  // The wait length is captured on entry so address changes mid-access cannot extend it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      wcnt  <= '0;
    end else if (tick) begin
      case (state)
        ST_RUN: begin
          if (sel_wait != '0) begin
            state <= ST_WAIT;
            wcnt  <= sel_wait - WAIT_W'(1);
          end
        end
        ST_WAIT: begin
          if (wcnt == '0) begin
            state <= ST_RUN;
          end else begin
            wcnt <= wcnt - WAIT_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

  assign we_out  = cs & {NUM_REGIONS{cpu_we & cpu_clken}};
  assign wr_data = cpu_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_din      <= '0;
      unmapped_cnt <= '0;
    end else begin
      cpu_din <= sel_data;
      if (cpu_clken && !hit) begin
        unmapped_cnt <= sat_inc(unmapped_cnt);
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Directed bench for cpu_bus_decoder: divider timing, decode priority, wait states, unmapped count, reset abort.
module tb_cpu_bus_decoder;

  localparam int NR      = 4;
  localparam int CLK_DIV = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_clken;
  logic          phi2;
  logic [NR-1:0] cs;
  logic [NR-1:0] we_out;
  logic [7:0]    wr_data;
  logic [8*NR-1:0] rd_data;
  logic [7:0]    unmapped_cnt;

  logic [7:0] rd_mem [NR];
  int tests_run;
  int tests_failed;
  int phase;
  int ticks;

  // r0: 0000-3FFF, r1: 8000-FFFF with 2 waits, r2: 0000-0FFF overlapping r0, r3 disabled.
  cpu_bus_decoder #(
    .NUM_REGIONS(NR),
    .CLK_DIV    (CLK_DIV),
    .REGION_BASE({16'h0000, 16'h0000, 16'h8000, 16'h0000}),
    .REGION_MASK({16'h0000, 16'hF000, 16'h8000, 16'hC000}),
    .REGION_WAIT({4'd0, 4'd0, 4'd2, 4'd0}),
    .OPEN_BUS   (8'hEE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .cpu_clken   (cpu_clken),
    .phi2        (phi2),
    .cs          (cs),
    .we_out      (we_out),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .unmapped_cnt(unmapped_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each region answers with a distinct, address-dependent byte one clk after the address.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      rd_mem[i] <= cpu_addr[7:0] ^ 8'(16 * (i + 1));
    end
  end
  assign rd_data = {rd_mem[3], rd_mem[2], rd_mem[1], rd_mem[0]};

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] dout);
    cpu_addr = addr;
    cpu_we   = we;
    cpu_dout = dout;
  endtask

  task automatic stepClock();
    @(posedge clk);
    phase = !rst_n ? 0 : (phase + 1) % CLK_DIV;
    @(negedge clk);
  endtask

  task automatic alignPhase();
    while (phase != 0) stepClock();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    phase        = 0;
    rst_n        = 1'b0;
    applyStimulus(16'h0005, 1'b0, 8'h00);
    repeat (3) stepClock();

    checkOutput("rst_clken", 16'(cpu_clken), 16'h0);
    checkOutput("rst_phi2", 16'(phi2), 16'h0);
    checkOutput("rst_din", 16'(cpu_din), 16'h00);
    checkOutput("rst_unmapped", 16'(unmapped_cnt), 16'h00);
    checkOutput("rst_we_out", 16'(we_out), 16'h0);
    checkOutput("cs_overlap", 16'(cs), 16'h1);

    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      stepClock();
      checkOutput("clken_period", 16'(cpu_clken), 16'(phase == CLK_DIV - 1));
      checkOutput("phi2_phase", 16'(phi2), 16'(phase >= CLK_DIV / 2));
    end
    checkOutput("din_overlap_r0", 16'(cpu_din), 16'h15);

    alignPhase();
    applyStimulus(16'h0005, 1'b1, 8'hA5);
    checkOutput("wr_data", 16'(wr_data), 16'hA5);
    for (int k = 0; k < 4; k++) begin
      stepClock();
      checkOutput("we_out_r0", 16'(we_out), (phase == CLK_DIV - 1) ? 16'h1 : 16'h0);
    end

    // Two-wait write to region 1; address moves mid-wait and must not restart the count.
    alignPhase();
    applyStimulus(16'h8010, 1'b1, 8'h3C);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      stepClock();
      if (phase == CLK_DIV - 1) ticks++;
      checkOutput("clken_wait", 16'(cpu_clken), 16'(phase == CLK_DIV - 1 && ticks == 3));
      checkOutput("we_out_wait", 16'(we_out), (phase == CLK_DIV - 1 && ticks == 3) ? 16'h2 : 16'h0);
      if (k == 4) applyStimulus(16'h8055, 1'b1, 8'h3C);
    end
    checkOutput("cs_r1", 16'(cs), 16'h2);
    checkOutput("din_r1", 16'(cpu_din), 16'h75);
    applyStimulus(16'h8055, 1'b0, 8'h00);

    alignPhase();
    applyStimulus(16'h4000, 1'b0, 8'h00);
    repeat (CLK_DIV) stepClock();
    checkOutput("cs_unmapped", 16'(cs), 16'h0);
    checkOutput("din_open_bus", 16'(cpu_din), 16'hEE);
    checkOutput("unmapped_1", 16'(unmapped_cnt), 16'h01);
    repeat (253 * CLK_DIV) stepClock();
    checkOutput("unmapped_254", 16'(unmapped_cnt), 16'hFE);
    repeat (46 * CLK_DIV) stepClock();
    checkOutput("unmapped_sat", 16'(unmapped_cnt), 16'hFF);

    // Enter WAIT on region 1, then pull reset before the access completes.
    alignPhase();
    applyStimulus(16'h8010, 1'b1, 8'h11);
    repeat (CLK_DIV + 1) stepClock();
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stepClock();
      checkOutput("clken_in_rst", 16'(cpu_clken), 16'h0);
    end
    checkOutput("rst2_phi2", 16'(phi2), 16'h0);
    checkOutput("rst2_din", 16'(cpu_din), 16'h00);
    checkOutput("rst2_unmapped", 16'(unmapped_cnt), 16'h00);
    checkOutput("rst2_we_out", 16'(we_out), 16'h0);

    rst_n = 1'b1;
    applyStimulus(16'h0005, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      stepClock();
      checkOutput("clken_after_rst", 16'(cpu_clken), 16'(phase == CLK_DIV - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_bus_decoder.md
CPU_BUS_DECODER -- requirements
Module: cpu_bus_decoder

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4: number of decoded memory regions (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per CPU cycle (3..16).
REQ-003 SHALL have parameter REGION_BASE, default {16'h8000,16'h0000,16'h0000,16'h0000}: packed 16-bit base per region, region 0 in LSBs.
REQ-004 SHALL have parameter REGION_MASK, default {16'h8000,16'h8000,16'h0000,16'h0000}: packed 16-bit compare mask per region; an all-zero mask disables the region.
REQ-005 SHALL have parameter REGION_WAIT, default 0: packed 4-bit extra CPU-cycle wait count per region.
REQ-006 SHALL have parameter OPEN_BUS, default 8'h00: read value for unmapped addresses.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 cpu_addr  in  16  CPU address bus.
REQ-010 cpu_we  in  1  CPU write request, high = write.
REQ-011 cpu_dout  in  8  CPU write data; passed through unchanged to wr_data.
REQ-012 cpu_din  out  8  registered read data to CPU.
REQ-013 cpu_clken  out  1  CPU clock enable, also driven to CPU ready.
REQ-014 phi2  out  1  phase-2 indicator for peripherals.
REQ-015 cs  out  NUM_REGIONS  one-hot region select, combinational from cpu_addr.
REQ-016 we_out  out  NUM_REGIONS  per-region write strobe.
REQ-017 wr_data  out  8  write data to all regions.
REQ-018 rd_data  in  8*NUM_REGIONS  packed read data from each region's synchronous memory.
REQ-019 unmapped_cnt  out  8  saturating count of unmapped accesses.

Function
REQ-020 Divider: counter div_cnt SHALL run 0..CLK_DIV-1 and wrap; tick = (div_cnt == CLK_DIV-1).
REQ-021 phi2 SHALL be registered, high when div_cnt >= CLK_DIV/2 (integer division), else low.
REQ-022 Decode: region i hits when (cpu_addr & MASK_i) == BASE_i and MASK_i != 0; the lowest hitting index wins; cs is one-hot or all zero.
REQ-023 FSM states RUN and WAIT; a 4-bit wcnt holds the remaining wait cycles.
REQ-024 RUN, tick, selected region has W = REGION_WAIT > 0: cpu_clken SHALL stay 0, wcnt <= W-1, next state WAIT.
REQ-025 RUN, tick, W = 0 or no hit: cpu_clken SHALL be 1 for exactly that clk cycle.
REQ-026 WAIT, tick, wcnt == 0: cpu_clken SHALL be 1, next state RUN; WAIT, tick, wcnt > 0: wcnt decrements.
REQ-027 An access with wait W SHALL therefore span W+1 divider periods; CPU-visible cycle rate is otherwise one per CLK_DIV clks.
REQ-028 we_out[i] SHALL be cpu_we & cs[i] & cpu_clken: exactly one clk-wide strobe per write, none during wait periods.
REQ-029 cpu_din SHALL be registered every clk from rd_data slice of the selected region, or OPEN_BUS when none selected; total latency addr->cpu_din = 2 clks (memory 1 + mux 1), valid before the next tick.
REQ-030 unmapped_cnt SHALL increment on every cpu_clken pulse with no region hit, saturating at 8'hFF.
REQ-031 cpu_addr changing during WAIT SHALL NOT restart the wait count; the wait count latched on entry governs.

Reset
REQ-032 While rst_n = 0 at a clk edge: div_cnt = 0, state = RUN, wcnt = 0, cpu_clken = 0, phi2 = 0, cpu_din = 8'h00, unmapped_cnt = 0; we_out SHALL be all zero.
REQ-033 Reset asserted mid-WAIT SHALL abort the access with no cpu_clken pulse; first tick after release is at clk CLK_DIV-1 counted from release.

Structure
REQ-034 Package cpu_bus_pkg SHALL hold the FSM state type, ADDR_W = 16, DATA_W = 8, WAIT_W = 4.
REQ-035 Divider plus phi2 SHALL be the sub-module clken_div (ports clk, rst_n, tick, phi2), instantiated once.

Verification
REQ-036 Defaults, CLK_DIV = 4, no waits -> cpu_clken pulses every 4th clk, first at clk 3 after reset release; phi2 high on div_cnt 2,3.
REQ-037 REGION_WAIT region1 = 2, cpu_addr = 16'h8010 -> two ticks with no cpu_clken, pulse on third tick (12 clks after start).
REQ-038 Write to 16'h0005 with cpu_we = 1 -> we_out = 4'b0001 for exactly one clk, coincident with cpu_clken; wr_data = cpu_dout.
REQ-039 Region masks leaving 16'h4000 unmapped (region0 mask 16'hC000 base 0), read 16'h4000 -> cpu_din = OPEN_BUS; unmapped_cnt +1; 300 such accesses -> 8'hFF.
REQ-040 Overlapping regions 0 and 2 both hit -> cs = 0001, cpu_din from rd_data[7:0].
REQ-041 rst_n low during WAIT -> no cpu_clken pulse, all outputs at reset values next edge.
